led_pwm_pio: RTL

//  Avalon-MM slave output PIO driving board LEDs from the HPS lightweight bridge; successor of the fixed 10-bit LED PIO.

---
 rtl/led_pwm_pio_pkg.sv | 15 +
 rtl/led_pwm_pio_timebase.sv | 43 ++++
 rtl/led_pwm_pio.sv | 89 ++++++++
 3 files changed

// File: rtl/led_pwm_pio_pkg.sv
// Shared register map and STATUS field layout for the LED PWM PIO.
package led_pwm_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLEAR    = 3'd2;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
    localparam logic [2:0] ADDR_PERIOD   = 3'd4;
    localparam logic [2:0] ADDR_DUTY     = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_PWM_LSB   = 16;

endpackage

// File: rtl/led_pwm_pio_timebase.sv
// Blink prescaler / phase and free-running PWM counter shared by all channels.
module led_pwm_pio_timebase #(
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic [PWM_BITS-1:0]    duty,
    input  logic                   period_wr,
    output logic                   blink_phase,
    output logic [PWM_BITS-1:0]    pwm_cnt,
    output logic                   pwm_on
);

    logic [PERIOD_BITS-1:0] presc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt   <= '0;
            blink_phase <= 1'b1;
            pwm_cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // A PERIOD write restarts the half-period but keeps the current phase.
            if (period_wr) begin
                presc_cnt <= '0;
            end else if (period == '0) begin
                presc_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (presc_cnt == period) begin
                presc_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                presc_cnt <= presc_cnt + PERIOD_BITS'(1);
            end
        end
    end

    // All-ones duty is a true 100%, not 255/256.
    assign pwm_on = (pwm_cnt < duty) | (&duty);

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED output PIO: register file with set/clear, per-channel blink, global PWM.
module led_pwm_pio
    import led_pwm_pio_pkg::*;
#(
    parameter int                      WIDTH        = 10,
    parameter int                      PWM_BITS     = 8,
    parameter int                      PERIOD_BITS  = 24,
    parameter logic [PERIOD_BITS-1:0]  RESET_PERIOD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]       data;
    logic [WIDTH-1:0]       blink_en;
    logic [PERIOD_BITS-1:0] period;
    logic [PWM_BITS-1:0]    duty;
    logic                   blink_phase;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   pwm_on;
    logic                   wr;
    logic [WIDTH-1:0]       wmask;

    assign wr    = chipselect & ~write_n;
    assign wmask = writedata[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= '0;
            blink_en <= '0;
            period   <= RESET_PERIOD;
            duty     <= '1;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data     <= wmask;
                ADDR_SET:      data     <= data | wmask;
                ADDR_CLEAR:    data     <= data & ~wmask;
                ADDR_BLINK_EN: blink_en <= wmask;
                ADDR_PERIOD:   period   <= writedata[PERIOD_BITS-1:0];
                ADDR_DUTY:     duty     <= writedata[PWM_BITS-1:0];
                default:       ;
            endcase
        end
    end

    led_pwm_pio_timebase #(
        .PWM_BITS    (PWM_BITS),
        .PERIOD_BITS (PERIOD_BITS)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .period      (period),
        .duty        (duty),
        .period_wr   (wr && (address == ADDR_PERIOD)),
        .blink_phase (blink_phase),
        .pwm_cnt     (pwm_cnt),
        .pwm_on      (pwm_on)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= '0;
        end else begin
            out_port <= data & (~blink_en | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]       = data;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]       = blink_en;
            ADDR_PERIOD:   readdata[PERIOD_BITS-1:0] = period;
            ADDR_DUTY:     readdata[PWM_BITS-1:0]    = duty;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT]              = blink_phase;
                readdata[STATUS_PWM_LSB +: PWM_BITS]    = pwm_cnt;
            end
            default:       ;
        endcase
    end

endmodule
